red_serial: RTL and testbench



---
 rtl/red_serial.sv | 120 ++++++++++++
 tb/tb_red_serial.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/red_serial.sv
// Serial signed byte-lane reduction: sums the four signed bytes of A and B
// through one shared 10-bit adder over LO/HI/SUM steps, with a valid/ready handshake on both sides.
module red_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    SUM  = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [8:0]  lo_q;
  logic [8:0]  hi_q;
  logic [15:0] out_q;
  logic        in_ready_q;
  logic        out_valid_q;

  logic [9:0]  add_a_s;
  logic [9:0]  add_b_s;
  logic [9:0]  add_sum_s;

  // Shared adder operand select: byte pairs in LO/HI, partial sums in SUM.
  always_comb begin
    add_a_s = 10'd0;
    add_b_s = 10'd0;
    case (state_q)
      LO: begin
        add_a_s = {{2{a_q[7]}}, a_q[7:0]};
        add_b_s = {{2{b_q[7]}}, b_q[7:0]};
      end
      HI: begin
        add_a_s = {{2{a_q[15]}}, a_q[15:8]};
        add_b_s = {{2{b_q[15]}}, b_q[15:8]};
      end
      SUM: begin
        add_a_s = {hi_q[8], hi_q};
        add_b_s = {lo_q[8], lo_q};
      end
      default: begin
        add_a_s = 10'd0;
        add_b_s = 10'd0;
      end
    endcase
    add_sum_s = add_a_s + add_b_s;
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      lo_q        <= 9'd0;
      hi_q        <= 9'd0;
      out_q       <= 16'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B;
            in_ready_q <= 1'b0;
            state_q    <= LO;
          end else begin
            state_q    <= IDLE;
          end
        end
        LO: begin
          lo_q    <= add_sum_s[8:0];
          state_q <= HI;
        end
        HI: begin
          hi_q    <= add_sum_s[8:0];
          state_q <= SUM;
        end
        SUM: begin
          out_q       <= {{6{add_sum_s[9]}}, add_sum_s};
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          // Out is deliberately left intact after the handoff.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q     <= HOLD;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Out       = out_q;

endmodule

// File: tb/tb_red_serial.sv
// Directed self-checking bench for red_serial: latency, extremes, backpressure,
// operand isolation, back-to-back throughput and asynchronous reset mid-operation.
module tb_red_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;

  int n_checks;
  int n_errors;

  red_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One operation: accept, 3-edge latency, optional backpressure, handoff.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input int hold, input string tag);
    out_ready = (hold == 0);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 16'hFFFF;
    B = 16'hFFFF;
    chk({tag, "_rdy_acc"}, in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk({tag, "_ov_lat"}, out_valid, 1'b0);
      chk({tag, "_rdy_lat"}, in_ready, 1'b0);
    end
    @(posedge clk); #1;
    chk({tag, "_ov"}, out_valid, 1'b1);
    chk({tag, "_out"}, Out, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      A = 16'h8080;
      B = 16'h8080;
      @(posedge clk); #1;
      chk({tag, "_bp_ov"}, out_valid, 1'b1);
      chk({tag, "_bp_out"}, Out, exp);
      chk({tag, "_bp_rdy"}, in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ho_ov"}, out_valid, 1'b0);
    chk({tag, "_ho_rdy"}, in_ready, 1'b1);
    chk({tag, "_ho_keep"}, Out, exp);
  endtask

  logic [15:0] va [4];
  logic [15:0] vb [4];
  logic [15:0] ve [4];
  logic [15:0] exp_q [$];
  int          vi;
  int          nres;
  int          last_c;
  logic        rdy_before;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A = 16'h0000;
    B = 16'h0000;
    va[0] = 16'h0102; vb[0] = 16'h0304; ve[0] = 16'h000A;
    va[1] = 16'h8080; vb[1] = 16'h8080; ve[1] = 16'hFE00;
    va[2] = 16'h7F7F; vb[2] = 16'h7F7F; ve[2] = 16'h01FC;
    va[3] = 16'hFF01; vb[3] = 16'h01FF; ve[3] = 16'h0000;

    #12;
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_out", Out, 16'h0000);
    rst_n = 1'b1;

    do_op(16'h0102, 16'h0304, 16'h000A, 0, "basic");
    do_op(16'h8080, 16'h8080, 16'hFE00, 0, "min");
    do_op(16'h7F7F, 16'h7F7F, 16'h01FC, 0, "max");
    do_op(16'hFF01, 16'h01FF, 16'h0000, 0, "zero");
    do_op(16'h7F01, 16'h0203, 16'h0085, 10, "bp");
    do_op(16'h0102, 16'h0304, 16'h000A, 0, "after_bp");

    // Back-to-back with in_valid and out_ready tied high.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    vi     = 0;
    nres   = 0;
    last_c = 0;
    A = va[0];
    B = vb[0];
    for (int c = 1; c <= 40; c++) begin
      rdy_before = in_ready;
      @(posedge clk); #1;
      if (rdy_before) begin
        exp_q.push_back(ve[vi % 4]);
        vi++;
        A = va[vi % 4];
        B = vb[vi % 4];
      end
      if (out_valid) begin
        chk("b2b_pending", 16'(exp_q.size() > 0), 16'd1);
        if (exp_q.size() > 0) chk("b2b_out", Out, exp_q.pop_front());
        if (nres > 0) chk("b2b_gap", 16'(c - last_c), 16'd5);
        last_c = c;
        nres++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 16'(nres), 16'd8);
    chk("b2b_accepts", 16'(vi), 16'd8);
    @(posedge clk); #1;
    chk("b2b_idle", in_ready, 1'b1);

    do_op(16'h0505, 16'h0505, 16'h0014, 0, "opchg");

    // Asynchronous reset while in HI.
    A = 16'h1234;
    B = 16'h1111;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rdy", in_ready, 1'b1);
    chk("arst_ov", out_valid, 1'b0);
    chk("arst_out", Out, 16'h0000);
    #10;
    chk("arst_hold_ov", out_valid, 1'b0);
    A = 16'h0001;
    B = 16'h0000;
    in_valid = 1'b1;
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0000, 16'h0001, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
